// File: rtl/corr_window_reader.sv
// Window sequencer and readout: snapshots the four window counts at each window end
// and streams them as a byte packet. Optional macro CORR_WINDOW_READER_CHECKSUM_EN adds an XOR trailer byte.
module corr_window_reader #(
  parameter int DATA_W = 8,
  parameter int TIME_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cg,
  input  logic              i_enable,
  input  logic [TIME_W-1:0] i_winStart,
  input  logic [TIME_W-1:0] i_t,
  input  logic [DATA_W-1:0] i_countX,
  input  logic [DATA_W-1:0] i_countY,
  input  logic [DATA_W-1:0] i_countIsect,
  input  logic [DATA_W-1:0] i_countSymdiff,
  output logic              o_tUpdate,
  output logic [TIME_W-1:0] o_tValue,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_busy
);

  localparam int NB     = DATA_W / 8;
  localparam int SNAP_W = 4 * DATA_W;
`ifdef CORR_WINDOW_READER_CHECKSUM_EN
  localparam int N      = 2 + 4 * NB;
`else
  localparam int N      = 1 + 4 * NB;
`endif
  localparam int IDX_W  = $clog2(N);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic              r_state;
  logic [6:0]        r_seq;
  logic              r_drop_pending;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_header;
  logic [SNAP_W-1:0] r_snap;

  logic              w_win_end;
  logic              w_accept;
  logic              w_last;
  logic              w_capture;
  logic [7:0]        w_byte;

  assign w_win_end = i_enable & (i_t == {TIME_W{1'b1}});
  assign o_tUpdate = w_win_end & ~i_rst;
  assign o_tValue  = i_winStart;
  assign w_accept  = (r_state == ST_SEND) & i_ready & i_cg;
  assign w_last    = (r_idx == IDX_W'(N - 1));
  assign w_capture = i_cg & w_win_end & (r_state == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_seq          <= 7'd0;
      r_drop_pending <= 1'b0;
      r_idx          <= '0;
    end else if (i_cg) begin
      if (w_accept) begin
        if (w_last) begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_win_end) begin
        r_seq <= r_seq + 7'd1;
        if (r_state == ST_IDLE) begin
          r_state        <= ST_SEND;
          r_idx          <= '0;
          r_drop_pending <= 1'b0;
        end else begin
          // A window ending while a packet drains (including its last byte) is lost.
          r_drop_pending <= 1'b1;
        end
      end
    end
  end

  // NOTE: the packet payload registers carry no reset; they are only observed
  // while SEND is active, which always follows a fresh capture.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_header <= {r_drop_pending, r_seq};
      r_snap   <= {i_countX, i_countY, i_countIsect, i_countSymdiff};
    end
  end

`ifdef CORR_WINDOW_READER_CHECKSUM_EN
  logic [7:0] w_csum;

  always_comb begin
    w_csum = r_header;
    for (int k = 0; k < 4 * NB; k++) begin
      w_csum = w_csum ^ r_snap[SNAP_W-1-8*k -: 8];
    end
  end
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_byte = 8'h00;
    if (r_idx == '0) begin
      w_byte = r_header;
    end
    for (int k = 0; k < 4 * NB; k++) begin
      if (r_idx == IDX_W'(k + 1)) begin
        w_byte = r_snap[SNAP_W-1-8*k -: 8];
      end
    end
`ifdef CORR_WINDOW_READER_CHECKSUM_EN
    if (w_last) begin
      w_byte = w_csum;
    end
`endif
  end

  assign o_valid = (r_state == ST_SEND);
  assign o_busy  = (r_state == ST_SEND);
  assign o_data  = (r_state == ST_SEND) ? w_byte : 8'h00;

endmodule

// File: tb/tb_corr_window_reader.sv
// Scoreboard bench for corr_window_reader: the driver predicts packets with a
// byte-count model, a negedge monitor pops and compares every accepted byte.
module tb_corr_window_reader;

  localparam int DATA_W = 8;
  localparam int TIME_W = 4;
  localparam int NB     = DATA_W / 8;
`ifdef CORR_WINDOW_READER_CHECKSUM_EN
  localparam int N      = 2 + 4 * NB;
`else
  localparam int N      = 1 + 4 * NB;
`endif
  localparam logic [TIME_W-1:0] TMAX = {TIME_W{1'b1}};

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_cg = 1'b1;
  logic              i_enable = 1'b0;
  logic [TIME_W-1:0] i_winStart = '0;
  logic [TIME_W-1:0] i_t = '0;
  logic [DATA_W-1:0] i_countX = '0;
  logic [DATA_W-1:0] i_countY = '0;
  logic [DATA_W-1:0] i_countIsect = '0;
  logic [DATA_W-1:0] i_countSymdiff = '0;
  logic              i_ready = 1'b0;
  logic              o_tUpdate;
  logic [TIME_W-1:0] o_tValue;
  logic              o_valid;
  logic [7:0]        o_data;
  logic              o_busy;

  corr_window_reader #(.DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cg(i_cg), .i_enable(i_enable),
    .i_winStart(i_winStart), .i_t(i_t),
    .i_countX(i_countX), .i_countY(i_countY),
    .i_countIsect(i_countIsect), .i_countSymdiff(i_countSymdiff),
    .o_tUpdate(o_tUpdate), .o_tValue(o_tValue),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model state: the bench acts as the time counter and tracks
  // outstanding packet bytes, sequence number and pending drop flag.
  logic [7:0]        exp_q[$];
  int                model_seq  = 0;
  bit                model_drop = 0;
  int                model_rem  = 0;
  logic [TIME_W-1:0] t_cur      = '0;
  logic [TIME_W-1:0] win_start  = '0;
  bit                rand_counts = 1;
  logic [DATA_W-1:0] cx, cy, ci, cs;

  task automatic push_packet();
    logic [DATA_W-1:0] cnts[4];
    logic [7:0] hdr, b, csum;
    cnts[0] = cx; cnts[1] = cy; cnts[2] = ci; cnts[3] = cs;
    hdr  = (model_drop ? 8'h80 : 8'h00) | 8'(model_seq);
    exp_q.push_back(hdr);
    csum = hdr;
    for (int c = 0; c < 4; c++) begin
      for (int k = NB - 1; k >= 0; k--) begin
        b = 8'(cnts[c] >> (8 * k));
        exp_q.push_back(b);
        csum = csum ^ b;
      end
    end
`ifdef CORR_WINDOW_READER_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
  endtask

  // Drive one cycle at posedge+1, predict its effect, then wait for the edge.
  task automatic drive(input logic rst, input logic cg, input logic en, input logic rdy);
    bit we, acc;
    if (rand_counts) begin
      cx = DATA_W'($urandom()); cy = DATA_W'($urandom());
      ci = DATA_W'($urandom()); cs = DATA_W'($urandom());
    end
    i_rst = rst; i_cg = cg; i_enable = en; i_ready = rdy;
    i_t = t_cur; i_winStart = win_start;
    i_countX = cx; i_countY = cy; i_countIsect = ci; i_countSymdiff = cs;
    we = en && (t_cur == TMAX);
    if (rst) begin
      model_seq = 0; model_drop = 0; model_rem = 0;
      exp_q.delete();
    end else if (cg) begin
      acc = rdy && (model_rem > 0);
      if (we) begin
        if (model_rem == 0) begin
          push_packet();
          model_drop = 0;
          model_rem  = N;
        end else begin
          model_drop = 1;
        end
        model_seq = (model_seq + 1) % 128;
      end
      if (acc) model_rem--;
    end
    @(posedge clk);
    #1;
    if (cg && !rst) t_cur = we ? win_start : t_cur + 1'b1;
  endtask

  // Monitor: samples mid-cycle, compares each byte that the next edge accepts.
  bit         mon_en    = 0;
  bit         prev_hold = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_byte;
  bit         mon_acc;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_acc = o_valid && i_ready && i_cg && !i_rst;
      check("tupdate", o_tUpdate, i_enable && (i_t == TMAX) && !i_rst);
      check("tvalue", o_tValue, i_winStart);
      check("busy", o_busy, o_valid);
      if (!o_valid) check("idle_data", o_data, 8'h00);
      if (prev_hold && o_valid) check("hold_data", o_data, prev_data);
      if (mon_acc) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", o_data, 32'hxxxx_xxxx);
        end else begin
          exp_byte = exp_q.pop_front();
          check("stream_byte", o_data, exp_byte);
        end
      end
      prev_hold = o_valid && !mon_acc && !i_rst;
      prev_data = o_data;
    end else begin
      prev_hold = 0;
    end
  end

  logic [7:0] held;

  initial begin
    cx = '0; cy = '0; ci = '0; cs = '0;
    @(posedge clk); #1;
    mon_en = 1;

    // Reset with a would-be window end present: tUpdate must stay low.
    t_cur = TMAX;
    repeat (3) drive(1, 1, 1, 1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);

    // Basic packet with fixed counts and latency checks.
    t_cur = '0; win_start = '0; rand_counts = 0;
    cx = 8'h12; cy = 8'h34; ci = 8'h05; cs = 8'h3B;
    repeat (15) drive(0, 1, 1, 1);
    drive(0, 1, 1, 1);
    rand_counts = 1;
    check("hdr_latency_valid", o_valid, 1'b1);
    check("hdr_latency_data", o_data, 8'h00);
    repeat (N) drive(0, 1, 1, 1);
    check("pkt_end_valid", o_valid, 1'b0);

    // Backpressure: ready toggles each cycle over a full window.
    for (int i = 0; i < 40; i++) drive(0, 1, 1, 1'(i % 2));

    // Drop: ready low across two window ends, then released.
    repeat (2) drive(1, 1, 1, 1);
    t_cur = '0;
    repeat (32) drive(0, 1, 1, 0);
    repeat (40) drive(0, 1, 1, 1);

    // Sequence wrap: 130 windows with continuous ready.
    repeat (2) drive(1, 1, 1, 1);
    t_cur = '0;
    repeat (130 * 16 + 8) drive(0, 1, 1, 1);

    // Reset mid-packet after byte 2 accepted.
    t_cur = TMAX;
    drive(0, 1, 1, 1);
    repeat (3) drive(0, 1, 1, 1);
    drive(1, 1, 1, 1);
    check("rst_mid_valid", o_valid, 1'b0);
    t_cur = '0;
    repeat (24) drive(0, 1, 1, 1);

    // Clock gate held for 3 cycles mid-packet with t at all-ones.
    t_cur = TMAX;
    drive(0, 1, 1, 1);
    held = o_data;
    t_cur = TMAX;
    repeat (3) drive(0, 0, 1, 1);
    check("cg_valid", o_valid, 1'b1);
    check("cg_data", o_data, held);
    repeat (40) drive(0, 1, 1, 1);

    // Randomized traffic: short windows, random gate/enable/ready.
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) win_start = TIME_W'($urandom_range(0, 15));
      drive(0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)));
    end

    // Drain and confirm nothing expected is left outstanding.
    repeat (40) drive(0, 1, 0, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_window_reader.md
# corr_window_reader

Window sequencer and readout for the correlator counter block. Drives the counter's window-start controls (tUpdate/tValue) from the counter's time output, snapshots the four window counts (X, Y, Isect, Symdiff) on the last cycle of each window, and serialises each snapshot as a byte packet on a valid/ready stream toward the host link. If a window ends while the previous packet is still draining, that window is dropped and the drop is flagged in the next header.

## Interface
Parameters:
- DATA_W, 8, count width; legal values 8, 16, 24, 32.
- TIME_W, 8, window time width; window ends when i_t equals all-ones.

Ports:
- i_clk  input  1  clock; the only clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_cg  input  1  clock-gate enable; 0 holds all state.
- i_enable  input  1  1 = windows are sequenced and read out.
- i_winStart  input  TIME_W  initial t value for each new window.
- i_t  input  TIME_W  counter's current t.
- i_countX, i_countY, i_countIsect, i_countSymdiff  input  DATA_W each  counter outputs.
- o_tUpdate  output  1  window-start strobe to the counter.
- o_tValue  output  TIME_W  equals i_winStart.
- o_valid  output  1  stream byte valid.
- i_ready  input  1  stream byte accepted when o_valid & i_ready & i_cg.
- o_data  output  8  stream byte.
- o_busy  output  1  1 while a packet is being sent.

## Operation
- Window end: winEnd = i_enable & (i_t == all-ones). o_tUpdate = winEnd & ~i_rst, combinational.
- Each cycle with i_cg=1 and winEnd=1:
  - seq (7 bits) increments modulo 128.
  - In IDLE: snapshot regs load the four i_count* values; header = {dropPending, seq value before increment}; dropPending clears; state goes to SEND.
  - In SEND: snapshot is not touched; dropPending sets (sticky).
- Packet byte order:
  - Byte 0: header.
  - Then countX, countY, countIsect, countSymdiff, each as DATA_W/8 bytes, MSB first.
  - Length N = 1 + 4*DATA_W/8 (5 for DATA_W=8).
- FSM:
  - IDLE: o_valid=0.
  - SEND: o_valid=1; a byte index advances on each accepted byte. Return to IDLE on acceptance of the last byte.
- Same-cycle collision: last byte accepted while winEnd=1 is a drop (state was SEND). The next packet is therefore required to carry header bit7=1.
- o_data holds stable while o_valid=1 and not accepted. o_data = 0 in IDLE.
- i_enable falling mid-packet: the packet in progress completes normally.
- i_cg=0: no state changes, no acceptance; outputs hold.

## Timing
- Reset values: state IDLE, o_valid=0, o_data=0, o_busy=0, seq=0, dropPending=0, o_tUpdate=0.
- Reset mid-packet: the packet is abandoned; reset values apply the next cycle.
- Header appears on o_data with o_valid=1 in the cycle after the capturing winEnd cycle.
- With i_ready held at 1: byte k is presented at capture+1+k. The last byte is accepted at capture+N, and o_valid=0 the cycle after that.
- Minimum window for zero drops with continuous ready: 2^TIME_W - i_winStart ≥ N+1 cycles (winStart=0 and TIME_W=8 gives 256 cycles, ample).
- o_busy = (state == SEND).

## Configuration
- CORR_WINDOW_READER_CHECKSUM_EN defined:
  - A trailing byte is appended to each packet: XOR of all preceding packet bytes.
  - N = 2 + 4*DATA_W/8.
- Undefined: no checksum byte; N as above.

## Test plan
- Basic packet:
  - Stimulus: DATA_W=8, TIME_W=4, winStart=0, i_ready=1. Counts at t=15: X=0x12, Y=0x34, I=0x05, S=0x3B.
  - Required: o_tUpdate=1 at t=15; then bytes 0x00,0x12,0x34,0x05,0x3B on consecutive cycles; with checksum, an extra byte 0x00^0x12^0x34^0x05^0x3B=0x18.
- Backpressure:
  - Stimulus: i_ready toggles 1/0 every cycle.
  - Required: each byte held stable until accepted; same 5 bytes, no loss or duplication.
- Drop:
  - Stimulus: i_ready=0 across two window ends.
  - Required: second window dropped; after release, the following window's header = 0x80 | seq with seq=2.
- Sequence wrap:
  - Stimulus: 130 consecutive windows, i_ready=1.
  - Required: header seq runs 0..127, then 0, 1; bit7=0 throughout.
- Reset mid-packet:
  - Stimulus: i_rst=1 after byte 2 is accepted.
  - Required: o_valid=0 the next cycle; next packet header = 0x00.
- Clock gate:
  - Stimulus: i_cg=0 for 3 cycles with o_valid=1 and i_ready=1.
  - Required: no byte accepted, o_data unchanged, seq unchanged even if i_t=all-ones.
